// File: rtl/call_return_ctrl_pkg.sv
// Shared sizing and FSM encoding for the call/return controller, its return
// stack memory and the surrounding PC datapath.
package call_return_ctrl_pkg;
   localparam int AW    = 10;
   localparam int DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      POP   = 2'd1,
      LOAD  = 2'd2,
      FAULT = 2'd3
   } state_t;
endpackage

// File: rtl/call_return_ctrl_depth_counter.sv
// Saturating up/down occupancy counter for the return stack, with full/empty flags.
module depth_counter #(
   parameter int DEPTH = call_return_ctrl_pkg::DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          dec,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty
);

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // Simultaneous inc/dec cancel; both directions clamp instead of wrapping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + CW'(1);
      end else if (dec && !inc && !empty) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/call_return_ctrl.sv
// Call/return sequencer: pushes return addresses on jal, pops and reloads the
// PC on ret, and parks in FAULT on stack overflow or underflow.
module call_return_ctrl #(
   parameter int AW    = call_return_ctrl_pkg::AW,
   parameter int DEPTH = call_return_ctrl_pkg::DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   jal,
   input  logic                   ret,
   input  logic [AW-1:0]          pc_plus1,
   input  logic [AW-1:0]          target,
   input  logic [AW-1:0]          stk_rdata,
   output logic                   stk_push,
   output logic                   stk_pop,
   output logic [AW-1:0]          stk_wdata,
   output logic                   pc_load,
   output logic [AW-1:0]          pc_next,
   output logic                   stall,
   output logic [$clog2(DEPTH):0] depth,
   output logic                   overflow,
   output logic                   underflow
);
   import call_return_ctrl_pkg::*;

   state_t        state_q, state_d;
   logic [AW-1:0] ret_addr_q;
   logic [AW-1:0] pc_last_q;
   logic [AW-1:0] next_c;
   logic          push_c, pop_c, load_c, stall_c;
   logic          inc, dec, full, empty;
   logic          set_ovf, set_unf, capture;

   depth_counter #(
      .DEPTH (DEPTH),
      .CW    ($clog2(DEPTH) + 1)
   ) u_depth (
      .clk   (clk),
      .reset (reset),
      .inc   (inc),
      .dec   (dec),
      .count (depth),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d = state_q;
      push_c  = 1'b0;
      pop_c   = 1'b0;
      load_c  = 1'b0;
      stall_c = 1'b0;
      next_c  = pc_last_q;
      inc     = 1'b0;
      dec     = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            // jal has priority; a coincident ret is dropped.
            if (jal) begin
               if (!full) begin
                  push_c = 1'b1;
                  load_c = 1'b1;
                  next_c = target;
                  inc    = 1'b1;
               end else begin
                  set_ovf = 1'b1;
                  state_d = FAULT;
               end
            end else if (ret) begin
               if (!empty) begin
                  pop_c   = 1'b1;
                  stall_c = 1'b1;
                  state_d = POP;
               end else begin
                  set_unf = 1'b1;
                  state_d = FAULT;
               end
            end
         end
         POP: begin
            stall_c = 1'b1;
            capture = 1'b1;
            state_d = LOAD;
         end
         LOAD: begin
            load_c  = 1'b1;
            next_c  = ret_addr_q;
            dec     = 1'b1;
            state_d = IDLE;
         end
         FAULT: begin
            stall_c = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are forced quiet while reset is held, even if requests are present.
   assign stk_push  = push_c & reset;
   assign stk_pop   = pop_c & reset;
   assign pc_load   = load_c & reset;
   assign stall     = stall_c & reset;
   assign stk_wdata = (push_c && reset) ? pc_plus1 : '0;
   assign pc_next   = reset ? next_c : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ret_addr_q <= '0;
         pc_last_q  <= '0;
         overflow   <= 1'b0;
         underflow  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) ret_addr_q <= stk_rdata;
         if (load_c)  pc_last_q  <= next_c;
         if (set_ovf) overflow   <= 1'b1;
         if (set_unf) underflow  <= 1'b1;
      end
   end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl: expected outputs queued per step and
// compared against the DUT shortly after inputs settle.
module tb_call_return_ctrl;

   logic       clk;
   logic       reset;
   logic       jal, ret;
   logic [9:0] pc_plus1, target, stk_rdata;
   logic       stk_push, stk_pop, pc_load, stall, overflow, underflow;
   logic [9:0] stk_wdata, pc_next;
   logic [4:0] depth;

   typedef struct packed {
      logic       push;
      logic       pop;
      logic [9:0] wdata;
      logic       load;
      logic [9:0] next;
      logic       stall;
      logic [4:0] depth;
      logic       ovf;
      logic       unf;
   } obs_t;

   obs_t  exp_q[$];
   string tag_q[$];
   int    total = 0;
   int    bad   = 0;

   call_return_ctrl #(.AW(10), .DEPTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .jal       (jal),
      .ret       (ret),
      .pc_plus1  (pc_plus1),
      .target    (target),
      .stk_rdata (stk_rdata),
      .stk_push  (stk_push),
      .stk_pop   (stk_pop),
      .stk_wdata (stk_wdata),
      .pc_load   (pc_load),
      .pc_next   (pc_next),
      .stall     (stall),
      .depth     (depth),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

   // Drive one cycle of inputs, queue the expected outputs, compare, advance.
   task automatic step(input string tag,
                       input logic j, input logic r, input logic [9:0] p1,
                       input logic [9:0] tg, input logic [9:0] rd,
                       input logic pu, input logic po, input logic [9:0] wd,
                       input logic ld, input logic [9:0] nx, input logic st,
                       input logic [4:0] dp, input logic ov, input logic un);
      obs_t o, e;
      string t;
      jal = j; ret = r; pc_plus1 = p1; target = tg; stk_rdata = rd;
      exp_q.push_back('{pu, po, wd, ld, nx, st, dp, ov, un});
      tag_q.push_back(tag);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      o = '{stk_push, stk_pop, stk_wdata, pc_load, pc_next, stall, depth, overflow, underflow};
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s: got push=%b pop=%b wdata=%h load=%b next=%h stall=%b depth=%0d ovf=%b unf=%b; need push=%b pop=%b wdata=%h load=%b next=%h stall=%b depth=%0d ovf=%b unf=%b",
                t, o.push, o.pop, o.wdata, o.load, o.next, o.stall, o.depth, o.ovf, o.unf,
                e.push, e.pop, e.wdata, e.load, e.next, e.stall, e.depth, e.ovf, e.unf);
      end
      @(negedge clk);
   endtask

   task automatic pulse_reset();
      jal = 1'b0; ret = 1'b0; pc_plus1 = '0; target = '0; stk_rdata = '0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      jal = 1'b0; ret = 1'b0; pc_plus1 = '0; target = '0; stk_rdata = '0;
      @(negedge clk);
      // Requests present while reset is held must not produce any strobe.
      step("reset_quiet", 1, 1, 10'h005, 10'h100, 10'h0, 0,0,10'h000,0,10'h000,0,0,0,0);
      reset = 1'b1;

      // Single call then return.
      step("call1",       1, 0, 10'h005, 10'h100, 10'h000, 1,0,10'h005,1,10'h100,0,0,0,0);
      step("call1_idle",  0, 0, 10'h000, 10'h000, 10'h000, 0,0,10'h000,0,10'h100,0,1,0,0);
      step("ret1_req",    0, 1, 10'h000, 10'h000, 10'h000, 0,1,10'h000,0,10'h100,1,1,0,0);
      step("ret1_pop",    1, 0, 10'h0AA, 10'h0BB, 10'h005, 0,0,10'h000,0,10'h100,1,1,0,0);
      step("ret1_load",   0, 0, 10'h000, 10'h000, 10'h000, 0,0,10'h000,1,10'h005,0,1,0,0);
      step("ret1_idle",   0, 0, 10'h000, 10'h000, 10'h000, 0,0,10'h000,0,10'h005,0,0,0,0);

      // Build depth 3, then jal+ret collide, then a jal under POP is ignored.
      step("call_a",      1, 0, 10'h011, 10'h200, 10'h000, 1,0,10'h011,1,10'h200,0,0,0,0);
      step("call_b",      1, 0, 10'h012, 10'h201, 10'h000, 1,0,10'h012,1,10'h201,0,1,0,0);
      step("call_c",      1, 0, 10'h013, 10'h202, 10'h000, 1,0,10'h013,1,10'h202,0,2,0,0);
      step("jal_ret_both",1, 1, 10'h014, 10'h203, 10'h000, 1,0,10'h014,1,10'h203,0,3,0,0);
      step("both_idle",   0, 0, 10'h000, 10'h000, 10'h000, 0,0,10'h000,0,10'h203,0,4,0,0);
      step("ret2_req",    0, 1, 10'h000, 10'h000, 10'h000, 0,1,10'h000,0,10'h203,1,4,0,0);
      step("ret2_pop_jal",1, 0, 10'h055, 10'h066, 10'h014, 0,0,10'h000,0,10'h203,1,4,0,0);
      step("ret2_load",   0, 0, 10'h000, 10'h000, 10'h000, 0,0,10'h000,1,10'h014,0,4,0,0);
      step("ret2_idle",   0, 0, 10'h000, 10'h000, 10'h000, 0,0,10'h000,0,10'h014,0,3,0,0);

      // Reset in the middle of LOAD aborts the return.
      step("ret3_req",    0, 1, 10'h000, 10'h000, 10'h000, 0,1,10'h000,0,10'h014,1,3,0,0);
      step("ret3_pop",    0, 0, 10'h000, 10'h000, 10'h013, 0,0,10'h000,0,10'h014,1,3,0,0);
      reset = 1'b0;
      step("rst_in_load", 0, 0, 10'h000, 10'h000, 10'h000, 0,0,10'h000,0,10'h000,0,0,0,0);
      reset = 1'b1;
      step("post_rst",    0, 0, 10'h000, 10'h000, 10'h000, 0,0,10'h000,0,10'h000,0,0,0,0);
      step("post_rst_jal",1, 0, 10'h021, 10'h300, 10'h000, 1,0,10'h021,1,10'h300,0,0,0,0);
      step("post_rst_dp", 0, 0, 10'h000, 10'h000, 10'h000, 0,0,10'h000,0,10'h300,0,1,0,0);

      // Fill the stack, then overflow.
      pulse_reset();
      for (int i = 0; i < 16; i++) begin
         step("fill", 1, 0, 10'(i + 1), 10'(256 + i), 10'h000,
              1, 0, 10'(i + 1), 1, 10'(256 + i), 0, 5'(i), 0, 0);
      end
      step("ovf_call",    1, 0, 10'h3FF, 10'h3FE, 10'h000, 0,0,10'h000,0,10'h10F,0,16,0,0);
      step("ovf_fault",   0, 0, 10'h000, 10'h000, 10'h000, 0,0,10'h000,0,10'h10F,1,16,1,0);
      step("ovf_hold",    1, 1, 10'h111, 10'h222, 10'h000, 0,0,10'h000,0,10'h10F,1,16,1,0);

      // Return on an empty stack.
      pulse_reset();
      step("unf_ret",     0, 1, 10'h000, 10'h000, 10'h000, 0,0,10'h000,0,10'h000,0,0,0,0);
      step("unf_fault",   0, 0, 10'h000, 10'h000, 10'h000, 0,0,10'h000,0,10'h000,1,0,0,1);
      step("unf_hold_ret",0, 1, 10'h000, 10'h000, 10'h000, 0,0,10'h000,0,10'h000,1,0,0,1);
      step("unf_hold_jal",1, 0, 10'h033, 10'h044, 10'h000, 0,0,10'h000,0,10'h000,1,0,0,1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
